// File: rtl/axi4_shared_pkg.sv
// Shared definitions for the Axi4Shared arbiter slice: default widths,
// response encodings and the width-independent part of the arw payload.
package axi4_shared_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W_DEF   = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    // Address and ID widths are parameters of the instance, so they travel beside this bundle.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       write;
    } arw_ctrl_t;

endpackage

// File: rtl/axi4_shared_arbiter_wq.sv
// Write-order queue: remembers which requester owns each accepted write
// command so W beats are routed in command order.
module axi4_shared_arbiter_wq #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi4_shared_arbiter.sv
// Two-requester Axi4Shared arbiter onto one SDRAM-controller port: round-robin
// arw, W ordered by the write-order queue, B/R routed back by the ID MSB.
module axi4_shared_arbiter
    import axi4_shared_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int WQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                s0_arw_valid,
    output logic                s0_arw_ready,
    input  logic [ADDR_W-1:0]   s0_arw_payload_addr,
    input  logic [ID_W-1:0]     s0_arw_payload_id,
    input  logic [7:0]          s0_arw_payload_len,
    input  logic [2:0]          s0_arw_payload_size,
    input  logic [1:0]          s0_arw_payload_burst,
    input  logic                s0_arw_payload_write,
    input  logic                s0_w_valid,
    output logic                s0_w_ready,
    input  logic [DATA_W-1:0]   s0_w_payload_data,
    input  logic [DATA_W/8-1:0] s0_w_payload_strb,
    input  logic                s0_w_payload_last,
    output logic                s0_b_valid,
    input  logic                s0_b_ready,
    output logic [ID_W-1:0]     s0_b_payload_id,
    output logic [1:0]          s0_b_payload_resp,
    output logic                s0_r_valid,
    input  logic                s0_r_ready,
    output logic [DATA_W-1:0]   s0_r_payload_data,
    output logic [ID_W-1:0]     s0_r_payload_id,
    output logic [1:0]          s0_r_payload_resp,
    output logic                s0_r_payload_last,

    input  logic                s1_arw_valid,
    output logic                s1_arw_ready,
    input  logic [ADDR_W-1:0]   s1_arw_payload_addr,
    input  logic [ID_W-1:0]     s1_arw_payload_id,
    input  logic [7:0]          s1_arw_payload_len,
    input  logic [2:0]          s1_arw_payload_size,
    input  logic [1:0]          s1_arw_payload_burst,
    input  logic                s1_arw_payload_write,
    input  logic                s1_w_valid,
    output logic                s1_w_ready,
    input  logic [DATA_W-1:0]   s1_w_payload_data,
    input  logic [DATA_W/8-1:0] s1_w_payload_strb,
    input  logic                s1_w_payload_last,
    output logic                s1_b_valid,
    input  logic                s1_b_ready,
    output logic [ID_W-1:0]     s1_b_payload_id,
    output logic [1:0]          s1_b_payload_resp,
    output logic                s1_r_valid,
    input  logic                s1_r_ready,
    output logic [DATA_W-1:0]   s1_r_payload_data,
    output logic [ID_W-1:0]     s1_r_payload_id,
    output logic [1:0]          s1_r_payload_resp,
    output logic                s1_r_payload_last,

    output logic                m_arw_valid,
    input  logic                m_arw_ready,
    output logic [ADDR_W-1:0]   m_arw_payload_addr,
    output logic [ID_W:0]       m_arw_payload_id,
    output logic [7:0]          m_arw_payload_len,
    output logic [2:0]          m_arw_payload_size,
    output logic [1:0]          m_arw_payload_burst,
    output logic                m_arw_payload_write,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_W-1:0]   m_w_payload_data,
    output logic [DATA_W/8-1:0] m_w_payload_strb,
    output logic                m_w_payload_last,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [ID_W:0]       m_b_payload_id,
    input  logic [1:0]          m_b_payload_resp,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [DATA_W-1:0]   m_r_payload_data,
    input  logic [ID_W:0]       m_r_payload_id,
    input  logic [1:0]          m_r_payload_resp,
    input  logic                m_r_payload_last
);

    logic       last_grant;
    logic       locked;
    logic       locked_idx;
    logic       grant;
    logic       arw_fire;
    logic [1:0] eligible;
    logic       wq_head;
    logic       wq_full;
    logic       wq_empty;
    logic       wq_pop;
    arw_ctrl_t  ctrl0;
    arw_ctrl_t  ctrl1;
    arw_ctrl_t  ctrl_sel;

    // A write cannot be offered while the order queue is full, even if a pop is due this cycle.
    assign eligible = {s1_arw_valid && !(s1_arw_payload_write && wq_full),
                       s0_arw_valid && !(s0_arw_payload_write && wq_full)};

    always_comb begin
        grant = ~last_grant;
        if (locked)                 grant = locked_idx;
        else if (eligible == 2'b01) grant = 1'b0;
        else if (eligible == 2'b10) grant = 1'b1;
    end

    assign ctrl0    = {s0_arw_payload_len, s0_arw_payload_size, s0_arw_payload_burst, s0_arw_payload_write};
    assign ctrl1    = {s1_arw_payload_len, s1_arw_payload_size, s1_arw_payload_burst, s1_arw_payload_write};
    assign ctrl_sel = grant ? ctrl1 : ctrl0;

    assign m_arw_valid         = reset && eligible[grant];
    assign m_arw_payload_addr  = grant ? s1_arw_payload_addr : s0_arw_payload_addr;
    assign m_arw_payload_id    = {grant, (grant ? s1_arw_payload_id : s0_arw_payload_id)};
    assign m_arw_payload_len   = ctrl_sel.len;
    assign m_arw_payload_size  = ctrl_sel.size;
    assign m_arw_payload_burst = ctrl_sel.burst;
    assign m_arw_payload_write = ctrl_sel.write;
    assign s0_arw_ready        = reset && !grant && eligible[0] && m_arw_ready;
    assign s1_arw_ready        = reset && grant && eligible[1] && m_arw_ready;
    assign arw_fire            = m_arw_valid && m_arw_ready;

    // The grant is frozen while a command is presented but not yet accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            locked     <= 1'b0;
            locked_idx <= 1'b0;
        end else if (arw_fire) begin
            last_grant <= grant;
            locked     <= 1'b0;
        end else begin
            locked     <= m_arw_valid;
            locked_idx <= grant;
        end
    end

    axi4_shared_arbiter_wq #(.DEPTH(WQ_DEPTH)) u_wq (
        .clk       (clk),
        .reset     (reset),
        .push      (arw_fire && m_arw_payload_write),
        .push_data (grant),
        .pop       (wq_pop),
        .head      (wq_head),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    assign m_w_valid        = reset && !wq_empty && (wq_head ? s1_w_valid : s0_w_valid);
    assign m_w_payload_data = wq_head ? s1_w_payload_data : s0_w_payload_data;
    assign m_w_payload_strb = wq_head ? s1_w_payload_strb : s0_w_payload_strb;
    assign m_w_payload_last = wq_head ? s1_w_payload_last : s0_w_payload_last;
    assign s0_w_ready       = reset && !wq_empty && !wq_head && m_w_ready;
    assign s1_w_ready       = reset && !wq_empty && wq_head && m_w_ready;
    assign wq_pop           = m_w_valid && m_w_ready && m_w_payload_last;

    // Responses carry the requester index in the ID MSB; it is stripped on the way back.
    assign s0_b_valid        = reset && m_b_valid && !m_b_payload_id[ID_W];
    assign s1_b_valid        = reset && m_b_valid && m_b_payload_id[ID_W];
    assign m_b_ready         = reset && (m_b_payload_id[ID_W] ? s1_b_ready : s0_b_ready);
    assign s0_b_payload_id   = m_b_payload_id[ID_W-1:0];
    assign s1_b_payload_id   = m_b_payload_id[ID_W-1:0];
    assign s0_b_payload_resp = m_b_payload_resp;
    assign s1_b_payload_resp = m_b_payload_resp;

    assign s0_r_valid        = reset && m_r_valid && !m_r_payload_id[ID_W];
    assign s1_r_valid        = reset && m_r_valid && m_r_payload_id[ID_W];
    assign m_r_ready         = reset && (m_r_payload_id[ID_W] ? s1_r_ready : s0_r_ready);
    assign s0_r_payload_id   = m_r_payload_id[ID_W-1:0];
    assign s1_r_payload_id   = m_r_payload_id[ID_W-1:0];
    assign s0_r_payload_data = m_r_payload_data;
    assign s1_r_payload_data = m_r_payload_data;
    assign s0_r_payload_resp = m_r_payload_resp;
    assign s1_r_payload_resp = m_r_payload_resp;
    assign s0_r_payload_last = m_r_payload_last;
    assign s1_r_payload_last = m_r_payload_last;

endmodule

// File: tb/tb_axi4_shared_arbiter.sv
// Directed bench for axi4_shared_arbiter: arbitration, write ordering,
// queue-full back-pressure, response routing, grant lock and reset.
module tb_axi4_shared_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic                s0_arw_valid, s0_arw_ready, s0_arw_payload_write;
    logic [ADDR_W-1:0]   s0_arw_payload_addr;
    logic [ID_W-1:0]     s0_arw_payload_id;
    logic [7:0]          s0_arw_payload_len;
    logic [2:0]          s0_arw_payload_size;
    logic [1:0]          s0_arw_payload_burst;
    logic                s0_w_valid, s0_w_ready, s0_w_payload_last;
    logic [DATA_W-1:0]   s0_w_payload_data;
    logic [DATA_W/8-1:0] s0_w_payload_strb;
    logic                s0_b_valid, s0_b_ready;
    logic [ID_W-1:0]     s0_b_payload_id;
    logic [1:0]          s0_b_payload_resp;
    logic                s0_r_valid, s0_r_ready, s0_r_payload_last;
    logic [DATA_W-1:0]   s0_r_payload_data;
    logic [ID_W-1:0]     s0_r_payload_id;
    logic [1:0]          s0_r_payload_resp;

    logic                s1_arw_valid, s1_arw_ready, s1_arw_payload_write;
    logic [ADDR_W-1:0]   s1_arw_payload_addr;
    logic [ID_W-1:0]     s1_arw_payload_id;
    logic [7:0]          s1_arw_payload_len;
    logic [2:0]          s1_arw_payload_size;
    logic [1:0]          s1_arw_payload_burst;
    logic                s1_w_valid, s1_w_ready, s1_w_payload_last;
    logic [DATA_W-1:0]   s1_w_payload_data;
    logic [DATA_W/8-1:0] s1_w_payload_strb;
    logic                s1_b_valid, s1_b_ready;
    logic [ID_W-1:0]     s1_b_payload_id;
    logic [1:0]          s1_b_payload_resp;
    logic                s1_r_valid, s1_r_ready, s1_r_payload_last;
    logic [DATA_W-1:0]   s1_r_payload_data;
    logic [ID_W-1:0]     s1_r_payload_id;
    logic [1:0]          s1_r_payload_resp;

    logic                m_arw_valid, m_arw_ready, m_arw_payload_write;
    logic [ADDR_W-1:0]   m_arw_payload_addr;
    logic [ID_W:0]       m_arw_payload_id;
    logic [7:0]          m_arw_payload_len;
    logic [2:0]          m_arw_payload_size;
    logic [1:0]          m_arw_payload_burst;
    logic                m_w_valid, m_w_ready, m_w_payload_last;
    logic [DATA_W-1:0]   m_w_payload_data;
    logic [DATA_W/8-1:0] m_w_payload_strb;
    logic                m_b_valid, m_b_ready;
    logic [ID_W:0]       m_b_payload_id;
    logic [1:0]          m_b_payload_resp;
    logic                m_r_valid, m_r_ready, m_r_payload_last;
    logic [DATA_W-1:0]   m_r_payload_data;
    logic [ID_W:0]       m_r_payload_id;
    logic [1:0]          m_r_payload_resp;

    axi4_shared_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .s0_arw_valid(s0_arw_valid), .s0_arw_ready(s0_arw_ready),
        .s0_arw_payload_addr(s0_arw_payload_addr), .s0_arw_payload_id(s0_arw_payload_id),
        .s0_arw_payload_len(s0_arw_payload_len), .s0_arw_payload_size(s0_arw_payload_size),
        .s0_arw_payload_burst(s0_arw_payload_burst), .s0_arw_payload_write(s0_arw_payload_write),
        .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready), .s0_w_payload_data(s0_w_payload_data),
        .s0_w_payload_strb(s0_w_payload_strb), .s0_w_payload_last(s0_w_payload_last),
        .s0_b_valid(s0_b_valid), .s0_b_ready(s0_b_ready), .s0_b_payload_id(s0_b_payload_id),
        .s0_b_payload_resp(s0_b_payload_resp),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_payload_data(s0_r_payload_data),
        .s0_r_payload_id(s0_r_payload_id), .s0_r_payload_resp(s0_r_payload_resp),
        .s0_r_payload_last(s0_r_payload_last),
        .s1_arw_valid(s1_arw_valid), .s1_arw_ready(s1_arw_ready),
        .s1_arw_payload_addr(s1_arw_payload_addr), .s1_arw_payload_id(s1_arw_payload_id),
        .s1_arw_payload_len(s1_arw_payload_len), .s1_arw_payload_size(s1_arw_payload_size),
        .s1_arw_payload_burst(s1_arw_payload_burst), .s1_arw_payload_write(s1_arw_payload_write),
        .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_payload_data(s1_w_payload_data),
        .s1_w_payload_strb(s1_w_payload_strb), .s1_w_payload_last(s1_w_payload_last),
        .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_payload_id(s1_b_payload_id),
        .s1_b_payload_resp(s1_b_payload_resp),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_payload_data(s1_r_payload_data),
        .s1_r_payload_id(s1_r_payload_id), .s1_r_payload_resp(s1_r_payload_resp),
        .s1_r_payload_last(s1_r_payload_last),
        .m_arw_valid(m_arw_valid), .m_arw_ready(m_arw_ready),
        .m_arw_payload_addr(m_arw_payload_addr), .m_arw_payload_id(m_arw_payload_id),
        .m_arw_payload_len(m_arw_payload_len), .m_arw_payload_size(m_arw_payload_size),
        .m_arw_payload_burst(m_arw_payload_burst), .m_arw_payload_write(m_arw_payload_write),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_payload_data(m_w_payload_data),
        .m_w_payload_strb(m_w_payload_strb), .m_w_payload_last(m_w_payload_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_payload_id(m_b_payload_id),
        .m_b_payload_resp(m_b_payload_resp),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_payload_data(m_r_payload_data),
        .m_r_payload_id(m_r_payload_id), .m_r_payload_resp(m_r_payload_resp),
        .m_r_payload_last(m_r_payload_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0_arw_valid = 0; s0_arw_payload_write = 0; s0_arw_payload_addr = '0; s0_arw_payload_id = '0;
        s0_arw_payload_len = '0; s0_arw_payload_size = 3'd2; s0_arw_payload_burst = 2'd1;
        s1_arw_valid = 0; s1_arw_payload_write = 0; s1_arw_payload_addr = '0; s1_arw_payload_id = '0;
        s1_arw_payload_len = '0; s1_arw_payload_size = 3'd2; s1_arw_payload_burst = 2'd1;
        s0_w_valid = 0; s0_w_payload_data = '0; s0_w_payload_strb = '1; s0_w_payload_last = 0;
        s1_w_valid = 0; s1_w_payload_data = '0; s1_w_payload_strb = '1; s1_w_payload_last = 0;
        s0_b_ready = 1; s1_b_ready = 1; s0_r_ready = 1; s1_r_ready = 1;
        m_arw_ready = 0; m_w_ready = 0;
        m_b_valid = 0; m_b_payload_id = '0; m_b_payload_resp = '0;
        m_r_valid = 0; m_r_payload_id = '0; m_r_payload_resp = '0; m_r_payload_data = '0; m_r_payload_last = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        s0_arw_valid = 1; s0_w_valid = 1; m_arw_ready = 1; m_w_ready = 1; m_b_valid = 1; m_r_valid = 1;
        #2;
        checks++; if (m_arw_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_arw_valid got=%0b exp=0", m_arw_valid); end
        checks++; if (s0_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_s0_arw_ready got=%0b exp=0", s0_arw_ready); end
        checks++; if (m_w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_w_valid got=%0b exp=0", m_w_valid); end
        checks++; if (s0_b_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_s0_b_valid got=%0b exp=0", s0_b_valid); end
        checks++; if (s0_r_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_s0_r_valid got=%0b exp=0", s0_r_valid); end
        checks++; if (m_b_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_b_ready got=%0b exp=0", m_b_ready); end
        tick(); tick();
        reset = 1;
        idle();
    endtask

    task automatic test_rr_reads();
        tick();
        s0_arw_valid = 1; s0_arw_payload_id = 2'b01; s0_arw_payload_addr = 25'h0000100;
        s1_arw_valid = 1; s1_arw_payload_id = 2'b11; s1_arw_payload_addr = 25'h0000200;
        m_arw_ready = 1;
        #1;
        checks++; if (m_arw_payload_id !== 3'b001) begin errors++; $display("[TB] FAIL rr_first_id got=%0b exp=001", m_arw_payload_id); end
        checks++; if (m_arw_payload_addr !== 25'h0000100) begin errors++; $display("[TB] FAIL rr_first_addr got=%0h exp=100", m_arw_payload_addr); end
        checks++; if (s0_arw_ready !== 1'b1 || s1_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_first_ready got=%0b%0b exp=01", s1_arw_ready, s0_arw_ready); end
        tick();
        checks++; if (m_arw_payload_id !== 3'b111) begin errors++; $display("[TB] FAIL rr_second_id got=%0b exp=111", m_arw_payload_id); end
        checks++; if (m_arw_payload_addr !== 25'h0000200) begin errors++; $display("[TB] FAIL rr_second_addr got=%0h exp=200", m_arw_payload_addr); end
        checks++; if (s1_arw_ready !== 1'b1 || s0_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_second_ready got=%0b%0b exp=10", s1_arw_ready, s0_arw_ready); end
        tick();
        idle();
    endtask

    task automatic test_write_order();
        s1_arw_valid = 1; s1_arw_payload_write = 1; s1_arw_payload_len = 8'd3; s1_arw_payload_id = 2'b10;
        m_arw_ready = 1;
        #1;
        checks++; if (s1_arw_ready !== 1'b1) begin errors++; $display("[TB] FAIL wo_s1_ready got=%0b exp=1", s1_arw_ready); end
        checks++; if (m_arw_payload_id !== 3'b110) begin errors++; $display("[TB] FAIL wo_s1_id got=%0b exp=110", m_arw_payload_id); end
        checks++; if (m_arw_payload_len !== 8'd3 || m_arw_payload_write !== 1'b1) begin errors++; $display("[TB] FAIL wo_s1_len got=%0d/%0b exp=3/1", m_arw_payload_len, m_arw_payload_write); end
        tick();
        s1_arw_valid = 0;
        s0_arw_valid = 1; s0_arw_payload_write = 1; s0_arw_payload_len = 8'd0; s0_arw_payload_id = 2'b00;
        #1;
        checks++; if (s0_arw_ready !== 1'b1 || m_arw_payload_len !== 8'd0) begin errors++; $display("[TB] FAIL wo_s0_cmd got=%0b/%0d exp=1/0", s0_arw_ready, m_arw_payload_len); end
        tick();
        idle();
        m_w_ready = 1;
        s0_w_valid = 1; s0_w_payload_data = 32'hA0A0_0000; s0_w_payload_last = 1;
        s1_w_valid = 1;
        for (int b = 0; b < 4; b++) begin
            s1_w_payload_data = 32'hB000_0000 + 32'(b);
            s1_w_payload_last = (b == 3);
            #1;
            checks++; if (m_w_valid !== 1'b1 || m_w_payload_data !== 32'hB000_0000 + 32'(b)) begin errors++; $display("[TB] FAIL wo_s1_beat%0d got=%0b/%0h exp=1/%0h", b, m_w_valid, m_w_payload_data, 32'hB000_0000 + 32'(b)); end
            checks++; if (s1_w_ready !== 1'b1 || s0_w_ready !== 1'b0) begin errors++; $display("[TB] FAIL wo_ready_beat%0d got=s1:%0b s0:%0b exp=s1:1 s0:0", b, s1_w_ready, s0_w_ready); end
            tick();
        end
        #1;
        checks++; if (m_w_payload_data !== 32'hA0A0_0000 || m_w_payload_last !== 1'b1) begin errors++; $display("[TB] FAIL wo_s0_beat got=%0h/%0b exp=a0a00000/1", m_w_payload_data, m_w_payload_last); end
        checks++; if (s0_w_ready !== 1'b1 || s1_w_ready !== 1'b0) begin errors++; $display("[TB] FAIL wo_s0_ready got=s0:%0b s1:%0b exp=s0:1 s1:0", s0_w_ready, s1_w_ready); end
        tick();
        #1;
        checks++; if (m_w_valid !== 1'b0 || s0_w_ready !== 1'b0 || s1_w_ready !== 1'b0) begin errors++; $display("[TB] FAIL wo_empty got=%0b%0b%0b exp=000", m_w_valid, s0_w_ready, s1_w_ready); end
        idle();
    endtask

    task automatic test_queue_full();
        m_arw_ready = 1;
        s0_arw_valid = 1; s0_arw_payload_write = 1; s0_arw_payload_id = 2'b01;
        for (int i = 0; i < 4; i++) begin
            s0_arw_payload_addr = 25'(i * 16);
            #1;
            checks++; if (s0_arw_ready !== 1'b1) begin errors++; $display("[TB] FAIL qf_push%0d got=%0b exp=1", i, s0_arw_ready); end
            tick();
        end
        s1_arw_valid = 1; s1_arw_payload_write = 0; s1_arw_payload_id = 2'b00; s1_arw_payload_addr = 25'h0000300;
        #1;
        checks++; if (s0_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL qf_s0_stall got=%0b exp=0", s0_arw_ready); end
        checks++; if (s1_arw_ready !== 1'b1 || m_arw_payload_id !== 3'b100) begin errors++; $display("[TB] FAIL qf_s1_read got=%0b/%0b exp=1/100", s1_arw_ready, m_arw_payload_id); end
        checks++; if (m_arw_payload_write !== 1'b0) begin errors++; $display("[TB] FAIL qf_read_write got=%0b exp=0", m_arw_payload_write); end
        tick();
        s1_arw_valid = 0;
        #1;
        checks++; if (m_arw_valid !== 1'b0 || s0_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL qf_alone_stall got=%0b/%0b exp=0/0", m_arw_valid, s0_arw_ready); end
        s0_arw_valid = 0;
        m_w_ready = 1; s0_w_valid = 1; s0_w_payload_last = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m_w_valid !== 1'b1 || s0_w_ready !== 1'b1) begin errors++; $display("[TB] FAIL qf_drain%0d got=%0b/%0b exp=1/1", i, m_w_valid, s0_w_ready); end
            tick();
        end
        #1;
        checks++; if (m_w_valid !== 1'b0) begin errors++; $display("[TB] FAIL qf_drained got=%0b exp=0", m_w_valid); end
        idle();
    endtask

    task automatic test_resp_route();
        m_r_valid = 1; m_r_payload_id = 3'b110; m_r_payload_last = 1; m_r_payload_data = 32'hDEAD_BEEF; m_r_payload_resp = 2'b01;
        s1_r_ready = 0; s0_r_ready = 1;
        #1;
        checks++; if (s1_r_valid !== 1'b1 || s0_r_valid !== 1'b0) begin errors++; $display("[TB] FAIL r_valid got=s1:%0b s0:%0b exp=s1:1 s0:0", s1_r_valid, s0_r_valid); end
        checks++; if (s1_r_payload_id !== 2'b10) begin errors++; $display("[TB] FAIL r_id got=%0b exp=10", s1_r_payload_id); end
        checks++; if (s1_r_payload_last !== 1'b1 || s1_r_payload_data !== 32'hDEAD_BEEF || s1_r_payload_resp !== 2'b01) begin errors++; $display("[TB] FAIL r_payload got=%0b/%0h/%0d exp=1/deadbeef/1", s1_r_payload_last, s1_r_payload_data, s1_r_payload_resp); end
        checks++; if (m_r_ready !== 1'b0) begin errors++; $display("[TB] FAIL r_ready_low got=%0b exp=0", m_r_ready); end
        s1_r_ready = 1;
        #1;
        checks++; if (m_r_ready !== 1'b1) begin errors++; $display("[TB] FAIL r_ready_high got=%0b exp=1", m_r_ready); end
        m_b_valid = 1; m_b_payload_id = 3'b011; m_b_payload_resp = 2'b10; s0_b_ready = 0;
        #1;
        checks++; if (s0_b_valid !== 1'b1 || s1_b_valid !== 1'b0) begin errors++; $display("[TB] FAIL b_valid got=s0:%0b s1:%0b exp=s0:1 s1:0", s0_b_valid, s1_b_valid); end
        checks++; if (s0_b_payload_id !== 2'b11 || s0_b_payload_resp !== 2'b10) begin errors++; $display("[TB] FAIL b_payload got=%0b/%0d exp=11/2", s0_b_payload_id, s0_b_payload_resp); end
        checks++; if (m_b_ready !== 1'b0) begin errors++; $display("[TB] FAIL b_ready got=%0b exp=0", m_b_ready); end
        idle();
    endtask

    task automatic test_lock();
        tick();
        s0_arw_valid = 1; s0_arw_payload_addr = 25'h0000040; m_arw_ready = 1;
        #1;
        checks++; if (s0_arw_ready !== 1'b1) begin errors++; $display("[TB] FAIL lk_pre got=%0b exp=1", s0_arw_ready); end
        tick();
        m_arw_ready = 0; s0_arw_payload_id = 2'b10; s0_arw_payload_addr = 25'h1ABCDE;
        #1;
        checks++; if (m_arw_valid !== 1'b1 || m_arw_payload_id !== 3'b010) begin errors++; $display("[TB] FAIL lk_offer got=%0b/%0b exp=1/010", m_arw_valid, m_arw_payload_id); end
        tick();
        s1_arw_valid = 1; s1_arw_payload_id = 2'b01; s1_arw_payload_addr = 25'h0000055;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (m_arw_payload_id !== 3'b010 || m_arw_payload_addr !== 25'h1ABCDE) begin errors++; $display("[TB] FAIL lk_hold%0d got=%0b/%0h exp=010/1abcde", c, m_arw_payload_id, m_arw_payload_addr); end
            checks++; if (s1_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL lk_s1_ready%0d got=%0b exp=0", c, s1_arw_ready); end
            tick();
        end
        m_arw_ready = 1;
        #1;
        checks++; if (s0_arw_ready !== 1'b1 || m_arw_payload_id !== 3'b010) begin errors++; $display("[TB] FAIL lk_accept got=%0b/%0b exp=1/010", s0_arw_ready, m_arw_payload_id); end
        tick();
        s0_arw_valid = 0;
        #1;
        checks++; if (s1_arw_ready !== 1'b1 || m_arw_payload_id !== 3'b101) begin errors++; $display("[TB] FAIL lk_s1_after got=%0b/%0b exp=1/101", s1_arw_ready, m_arw_payload_id); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_burst();
        s1_arw_valid = 1; s1_arw_payload_write = 1; s1_arw_payload_len = 8'd1; m_arw_ready = 1;
        #1;
        checks++; if (s1_arw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_s1_cmd got=%0b exp=1", s1_arw_ready); end
        tick();
        s1_arw_valid = 0; s0_arw_valid = 1;
        #1;
        checks++; if (s0_arw_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_s0_read got=%0b exp=1", s0_arw_ready); end
        tick();
        s0_arw_valid = 0; m_arw_ready = 0;
        m_w_ready = 1; s1_w_valid = 1; s1_w_payload_data = 32'h1234_5678; s1_w_payload_last = 0;
        #1;
        checks++; if (m_w_valid !== 1'b1 || s1_w_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_beat0 got=%0b/%0b exp=1/1", m_w_valid, s1_w_ready); end
        tick();
        s1_w_payload_last = 1;
        s0_arw_valid = 1; s1_arw_valid = 1; s1_arw_payload_write = 0; m_arw_ready = 1;
        m_b_valid = 1; m_b_payload_id = 3'b100; m_r_valid = 1; m_r_payload_id = 3'b000;
        #1;
        reset = 0;
        #1;
        checks++; if (m_w_valid !== 1'b0 || s1_w_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_w_async got=%0b/%0b exp=0/0", m_w_valid, s1_w_ready); end
        checks++; if (m_arw_valid !== 1'b0 || s0_arw_ready !== 1'b0 || s1_arw_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_arw_async got=%0b%0b%0b exp=000", m_arw_valid, s0_arw_ready, s1_arw_ready); end
        checks++; if (s1_b_valid !== 1'b0 || s0_r_valid !== 1'b0 || m_b_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_resp_async got=%0b%0b%0b exp=000", s1_b_valid, s0_r_valid, m_b_ready); end
        tick();
        reset = 1;
        m_b_valid = 0; m_r_valid = 0;
        #1;
        checks++; if (m_w_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_queue_empty got=%0b exp=0", m_w_valid); end
        checks++; if (s0_arw_ready !== 1'b1 || s1_arw_ready !== 1'b0 || m_arw_payload_id[ID_W] !== 1'b0) begin errors++; $display("[TB] FAIL rm_s0_priority got=%0b%0b/%0b exp=01/0xx", s1_arw_ready, s0_arw_ready, m_arw_payload_id); end
        tick();
        idle();
    endtask

    initial begin
        $display("[TB] axi4_shared_arbiter directed tests");
        test_reset();
        test_rr_reads();
        test_write_order();
        test_queue_full();
        test_resp_route();
        test_lock();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/axi4_shared_arbiter.md
AXI4_SHARED_ARBITER -- requirements
Module: axi4_shared_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 25, address width; DATA_W, default 32, data width; ID_W, default 2, per-input ID width; WQ_DEPTH, default 4, write-order queue depth (power of 2).
REQ-002 SHALL have port: clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports, per input i=0,1, named s{i}_arw_{valid,ready,payload_addr,payload_id,payload_len,payload_size,payload_write}  in/out/in/in/in/in/in  1/1/ADDR_W/ID_W/8/3/1  Axi4Shared command channel from requester i.
REQ-005 SHALL have ports: s{i}_arw_payload_burst  input  2  burst type.
REQ-006 SHALL have ports: s{i}_w_{valid,ready,payload_data,payload_strb,payload_last}  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  write data from requester i.
REQ-007 SHALL have ports: s{i}_b_{valid,ready,payload_id,payload_resp}  out/in/out/out  1/1/ID_W/2  write response to requester i.
REQ-008 SHALL have ports: s{i}_r_{valid,ready,payload_data,payload_id,payload_resp,payload_last}  out/in/out/out/out/out  1/1/DATA_W/ID_W/2/1  read data to requester i.
REQ-009 SHALL have ports: m_arw_*, m_w_*, m_b_*, m_r_* mirroring REQ-004..008 with opposite directions; the m_* ID width is ID_W+1. This single Axi4Shared master port drives the SDRAM controller.

Function
REQ-010 SHALL build m_arw_payload_id as {grant index, s_arw_payload_id}; all other arw fields SHALL pass through unmodified from the granted input.
REQ-011 SHALL arbitrate arw round-robin: the input not granted last wins a tie; after reset s0 has priority.
REQ-012 SHALL mux arw combinationally (0-cycle latency); m_arw_valid = granted s_arw_valid.
REQ-013 SHALL lock the grant while m_arw_valid=1 and m_arw_ready=0; the payload and grant stay stable until the handshake.
REQ-014 SHALL update the last-granted pointer only on an m_arw handshake.
REQ-015 SHALL hold s{i}_arw_ready=0 for any non-granted input.
REQ-016 SHALL push the grant index into the write-order queue on each accepted write command (payload_write=1).
REQ-017 SHALL not offer a write command when the queue is full: such a candidate is excluded from arbitration. Reads are unaffected. A push is not allowed even if a pop occurs in the same cycle.
REQ-018 SHALL route W from the input at the queue head; m_w_valid=0 and all s_w_ready=0 when the queue is empty; the non-head input's w_ready SHALL be 0.
REQ-019 SHALL pop the queue on an m_w handshake with payload_last=1; a push and a pop in the same cycle are both honoured when the queue is not full.
REQ-020 SHALL route B by m_b_payload_id[ID_W]: the selected s_b_valid=m_b_valid, m_b_ready=selected s_b_ready, the other s_b_valid=0, ID MSB stripped.
REQ-021 SHALL route R identically by m_r_payload_id[ID_W], passing data, resp and last unchanged.
REQ-022 SHALL add no buffering on B/R; latency is 0 cycles.

Reset
REQ-023 SHALL, while reset=0, clear the queue (empty), the lock and the pointer (s0 priority), and drive all valid/ready outputs to 0.
REQ-024 SHALL, on reset mid-burst, abandon in-flight W routing; recovery is the downstream controller's responsibility.

Structure
REQ-025 SHALL place ADDR_W/DATA_W/ID_W defaults, the resp encodings (OKAY=0) and the arw payload bundle typedef in the shared axi4_shared_pkg.
REQ-026 SHALL implement the write-order queue as the sub-module axi4_shared_arbiter_wq: a synchronous FIFO of 1-bit entries with full/empty flags.

Verification
REQ-027 The bench SHALL cover: s0 and s1 arw_valid together, both reads, m_arw_ready=1 -> s0 granted first, s1 next cycle, m ids 0b0xx then 0b1xx.
REQ-028 The bench SHALL cover: s1 write len=3 granted, then s0 write len=0 -> W routes 4 beats from s1, then 1 beat from s0; s0_w_ready=0 during s1 beats.
REQ-029 The bench SHALL cover: 4 writes accepted with W held off -> queue full; a 5th write stalls (ready=0) while a concurrent read from the other input is granted.
REQ-030 The bench SHALL cover: m_r with id=0b110, last=1 -> s1_r_valid=1, s1_r_payload_id=2'b10, s0_r_valid=0.
REQ-031 The bench SHALL cover: m_arw_ready=0 for 3 cycles with s0 granted while s1 asserts -> grant and payload stable; s1 granted only after the s0 handshake.
REQ-032 The bench SHALL cover: reset asserted mid write burst -> all valids 0 asynchronously; after release the queue is empty and s0 has priority.
